// File: rtl/sar_search.sv
// Successive-approximation binary search over a WIDTH-bit range, probing an
// external comparator with a registered guess, one comparison per clock.
module sar_search #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cmp_gt,
   input  logic             cmp_lt,
   input  logic             cmp_eq,
   output logic [WIDTH-1:0] guess,
   output logic             busy,
   output logic             done,
   output logic             found,
   output logic [WIDTH-1:0] result,
   output logic             err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] MAX_VAL = '1;
   localparam logic [WIDTH:0]   ONE     = 1;

   state_t           state;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] hi;
   logic [WIDTH:0]   sum_dn;
   logic [WIDTH:0]   sum_up;
   logic [WIDTH-1:0] mid_dn;
   logic [WIDTH-1:0] mid_up;
   logic [2:0]       flags;

   // Sums carry one extra bit so the midpoint never wraps at the range ends.
   always_comb begin
      sum_dn = {1'b0, lo} + {1'b0, guess} - ONE;
      sum_up = {1'b0, guess} + ONE + {1'b0, hi};
      mid_dn = WIDTH'(sum_dn >> 1);
      mid_up = WIDTH'(sum_up >> 1);
      flags  = {cmp_gt, cmp_lt, cmp_eq};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         guess  <= '0;
         result <= '0;
         lo     <= '0;
         hi     <= MAX_VAL;
         busy   <= 1'b0;
         done   <= 1'b0;
         found  <= 1'b0;
         err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= SEARCH;
                  busy  <= 1'b1;
                  lo    <= '0;
                  hi    <= MAX_VAL;
                  guess <= {1'b0, MAX_VAL[WIDTH-1:1]};
                  found <= 1'b0;
                  err   <= 1'b0;
               end
            end
            SEARCH: begin
               case (flags)
                  3'b001: begin
                     result <= guess;
                     found  <= 1'b1;
                     err    <= 1'b0;
                     state  <= DONE;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                  end
                  3'b100: begin
                     if (guess == lo) begin
                        found <= 1'b0;
                        err   <= 1'b0;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end else begin
                        hi    <= guess - 1'b1;
                        guess <= mid_dn;
                     end
                  end
                  3'b010: begin
                     if (guess == hi) begin
                        found <= 1'b0;
                        err   <= 1'b0;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end else begin
                        lo    <= guess + 1'b1;
                        guess <= mid_up;
                     end
                  end
                  default: begin
                     result <= guess;
                     found  <= 1'b0;
                     err    <= 1'b1;
                     state  <= DONE;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                  end
               endcase
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 Parameter: WIDTH, default 4, the bit width of the searched value and of guess/result.
REQ-002 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin a search; sampled only in IDLE.
REQ-005 cmp_gt  input  1  external comparator flag: guess > target.
REQ-006 cmp_lt  input  1  external comparator flag: guess < target.
REQ-007 cmp_eq  input  1  external comparator flag: guess == target.
REQ-008 guess  output  WIDTH  registered probe value driven to the external comparator.
REQ-009 busy  output  1  high while in SEARCH.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 found  output  1  valid with done and held after it; 1 means the target was located.
REQ-012 result  output  WIDTH  located value; held until the next accepted start.
REQ-013 err  output  1  valid with done and held after it; 1 means illegal comparator flags were seen.

Function
REQ-014 States SHALL be IDLE, SEARCH and DONE, with internal bounds lo and hi, each WIDTH bits wide.
REQ-015 In IDLE, start=1 SHALL set lo=0 and hi=2^WIDTH-1 and load guess=(2^WIDTH-1)>>1 (7 for WIDTH=4), moving to SEARCH on the same edge.
REQ-016 In IDLE, start=0 SHALL leave the state and all outputs unchanged.
REQ-017 The comparator flags are combinational on guess, so SEARCH SHALL sample them at every rising edge, one comparison per cycle.
REQ-018 SEARCH, cmp_eq only: result=guess, found=1, err=0, go to DONE.
REQ-019 SEARCH, cmp_gt only with guess==lo: found=0, err=0, go to DONE; this guard prevents hi underflow.
REQ-020 SEARCH, cmp_gt only otherwise: hi=guess-1, guess=(lo+guess-1)>>1, stay in SEARCH.
REQ-021 SEARCH, cmp_lt only with guess==hi: found=0, err=0, go to DONE; this guard prevents lo overflow.
REQ-022 SEARCH, cmp_lt only otherwise: lo=guess+1, guess=(guess+1+hi)>>1, stay in SEARCH.
REQ-023 Every midpoint sum SHALL be computed WIDTH+1 bits wide so it cannot wrap.
REQ-024 SEARCH, any flag combination other than exactly one flag set (none, or two or more): err=1, found=0, result=guess, go to DONE.
REQ-025 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-026 found, err and result SHALL persist in IDLE until the next accepted start, which clears found and err.
REQ-027 start asserted in SEARCH or DONE SHALL be ignored; no queuing.
REQ-028 A search SHALL use at most WIDTH+1 comparisons; start edge to done-high latency = comparisons + 1 cycles.
REQ-029 busy SHALL equal (state==SEARCH) and done SHALL equal (state==DONE), both decoded from registered state.
REQ-030 guess SHALL change only on entry to SEARCH and on SEARCH updates; it holds its last value in DONE and IDLE.

Reset
REQ-031 rst_n=0 SHALL immediately, independent of clk, force state=IDLE and set guess, result, lo, busy, done, found and err to 0 and hi to 2^WIDTH-1.
REQ-032 Reset asserted mid-search SHALL abandon the search with no done pulse.
REQ-033 After rst_n rises, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Verification
REQ-034 Target 7, ideal comparator model: one comparison, done two cycles after start, found=1, result=7.
REQ-035 Target 15: guesses 7, 11, 13, 14, 15 in that order; found=1, result=15, done six cycles after start.
REQ-036 Target 0: guesses 7, 3, 1, 0; found=1, result=0; no underflow or wrap.
REQ-037 Force cmp_gt=1 for all guesses (no valid target): guesses 7, 3, 1, 0, then done with found=0 and err=0.
REQ-038 Force cmp_gt=1 and cmp_lt=1 together on the second comparison: done with err=1 and result=3; start pulsed during SEARCH is ignored.
REQ-039 Drop rst_n during the third comparison for target 12: outputs go to zero immediately with no done pulse; a later start with target 12 completes with result=12.
